machine_ctrl: RTL
=================

MACHINE_CTRL -- requirements
Module: machine_ctrl

Interface
REQ-001 SHALL have no parameters; opcode and state encodings come from the shared package.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  cycle enable from the clock generator; state advances only when 1.
REQ-005 opcode  input  3  current instruction opcode from the instruction register (0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP).
REQ-006 zero  input  1  accumulator-is-zero flag.
REQ-007 inc_pc  output  1  program-counter increment strobe.
REQ-008 load_pc  output  1  program-counter load-from-IR-address select.
REQ-009 load_acc  output  1  accumulator load strobe.
REQ-010 load_ir  output  1  instruction-register byte load strobe.
REQ-011 rd / wr  output  1 each  memory read / write strobes.
REQ-012 datactl_ena  output  1  enables accumulator onto the data bus.
REQ-013 halt  output  1  CPU halted indicator.

Function
REQ-014 SHALL be a Moore/Mealy FSM with states S0..S7 plus HALTED; S0->S1->...->S7->S0, one step per clk with ena=1.
REQ-015 Outputs SHALL be combinational from state, opcode and zero; every output not listed for a state SHALL be 0.
REQ-016 S0: rd=1, load_ir=1 (fetch high byte).
REQ-017 S1: rd=1, load_ir=1, inc_pc=1 (fetch low byte).
REQ-018 S2: all strobes 0 (decode).
REQ-019 S3: inc_pc=1; if opcode=HLT then halt=1 and next state SHALL be HALTED instead of S4.
REQ-020 S4: JMP -> load_pc=1; ADD/AND/XOR/LDA -> rd=1; STO -> datactl_ena=1.
REQ-021 S5: ADD/AND/XOR/LDA -> rd=1, load_acc=1; SKZ with zero=1 -> inc_pc=1; JMP -> load_pc=1, inc_pc=1; STO -> wr=1, datactl_ena=1.
REQ-022 S6: ADD/AND/XOR/LDA -> rd=1; STO -> datactl_ena=1.
REQ-023 S7: SKZ with zero=1 -> inc_pc=1; all other opcodes 0.
REQ-024 HALTED: halt=1, all strobes 0, state held until reset.
REQ-025 ena=0: state frozen, all strobes forced 0; halt still reflects HALTED; on ena returning to 1 the sequence resumes from the frozen state.
REQ-026 inc_pc SHALL be asserted in at most one contiguous run of cycles per state visit, since it acts as the PC clock edge.
REQ-027 opcode and zero changes in S0/S1 SHALL NOT affect outputs (only state-only terms used there).

Reset
REQ-028 rst_n=0 SHALL force state S0 immediately, including from HALTED or mid-instruction.
REQ-029 While rst_n=0 all outputs SHALL be 0 (S0 strobes gated by rst_n).
REQ-030 First posedge after rst_n deasserts with ena=1 SHALL be spent in S0 (outputs of S0 visible), then advance to S1.

Configuration
REQ-031 Macro MACHINE_CTRL_SINGLE_STEP_EN SHALL add input step (1 bit).
REQ-032 With macro: S0 SHALL advance to S1 only when ena=1 and step=1; in S0 with step=0, strobes forced 0.
REQ-033 Without macro: step port absent; S0 advances on every ena=1 cycle.

Structure
REQ-034 cpu_pkg SHALL hold opcode constants (HLT..JMP) and the state enumeration typedef; the program counter, IR and ALU import the same opcodes.
REQ-035 No sub-module; single FSM with separate state register and output decode.

Verification
REQ-036 Reset: rst_n=0 during S5 of ADD -> all outputs 0 at once; after release, S0 with rd=1, load_ir=1.
REQ-037 JMP (opcode=7), ena=1 -> load_pc=1 in S4 and S5, inc_pc=1 in S1, S3, S5; back to S0 after 8 cycles.
REQ-038 SKZ with zero=1 -> inc_pc pulses in S1, S3, S5, S7; with zero=0 -> only S1, S3.
REQ-039 STO -> datactl_ena=1 in S4-S6, wr=1 only in S5; rd=0 in S4-S7.
REQ-040 HLT -> halt=1 from S3, enter HALTED, outputs stay quiet for 20 cycles; ena toggling has no effect; rst_n=0 clears.
REQ-041 ena=0 held 3 cycles in S4 of LDA -> rd=0 while frozen, state still S4 on resume, load_acc pulse in S5 exactly once; with MACHINE_CTRL_SINGLE_STEP_EN, step=0 holds S0 for 10 cycles with load_ir=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: opcode constants, controller state encoding and
// opcode classification helpers used by the controller, PC, IR and ALU.
package cpu_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    // Opcodes that read a memory operand into the accumulator
    function automatic logic is_mem_rd(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/machine_ctrl_if.sv
// Controller bus: sequencing inputs from the CPU and strobes back to it.
// Optional macro MACHINE_CTRL_SINGLE_STEP_EN adds the single-step input.
interface machine_ctrl_if;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
    logic       step;
`endif
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic       load_ir;
    logic       rd;
    logic       wr;
    logic       datactl_ena;
    logic       halt;

    modport master (
        output ena, opcode, zero,
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
        output step,
`endif
        input  inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt
    );

    modport slave (
        input  ena, opcode, zero,
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
        input  step,
`endif
        output inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt
    );
endinterface

// File: rtl/machine_ctrl.sv
// CPU machine controller: eight-phase instruction sequencer with a HALTED
// trap state. Strobes are decoded combinationally from state/opcode/zero.
// Optional macro MACHINE_CTRL_SINGLE_STEP_EN gates S0 on the step input.
module machine_ctrl
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    machine_ctrl_if.slave  bus
);

    state_t r_state;
    state_t w_seq;
    logic   w_open;
    logic   w_inc_pc, w_load_pc, w_load_acc, w_load_ir;
    logic   w_rd, w_wr, w_datactl, w_halt;
    logic   w_mem, w_skip, w_gate;

    assign w_mem  = is_mem_rd(bus.opcode);
    assign w_skip = (bus.opcode == SKZ) && bus.zero;

`ifdef MACHINE_CTRL_SINGLE_STEP_EN
    assign w_open = (r_state != S0) || bus.step;
`else
    assign w_open = 1'b1;
`endif

    // State register; frozen when the cycle enable (or single-step gate) is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S0;
        else if (bus.ena && w_open)
            r_state <= w_seq;
    end

    // Successor state and raw strobes for the current phase
    always_comb begin
        w_seq      = r_state;
        w_inc_pc   = 1'b0;
        w_load_pc  = 1'b0;
        w_load_acc = 1'b0;
        w_load_ir  = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_datactl  = 1'b0;
        w_halt     = 1'b0;
        unique case (r_state)
            S0: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
                w_seq     = S1;
            end
            S1: begin
                w_rd      = 1'b1;
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
                w_seq     = S2;
            end
            S2: w_seq = S3;
            S3: begin
                w_inc_pc = 1'b1;
                if (bus.opcode == HLT) begin
                    w_halt = 1'b1;
                    w_seq  = HALTED;
                end else begin
                    w_seq  = S4;
                end
            end
            S4: begin
                w_load_pc = (bus.opcode == JMP);
                w_rd      = w_mem;
                w_datactl = (bus.opcode == STO);
                w_seq     = S5;
            end
            S5: begin
                w_rd       = w_mem;
                w_load_acc = w_mem;
                w_inc_pc   = w_skip || (bus.opcode == JMP);
                w_load_pc  = (bus.opcode == JMP);
                w_wr       = (bus.opcode == STO);
                w_datactl  = (bus.opcode == STO);
                w_seq      = S6;
            end
            S6: begin
                w_rd      = w_mem;
                w_datactl = (bus.opcode == STO);
                w_seq     = S7;
            end
            S7: begin
                w_inc_pc = w_skip;
                w_seq    = S0;
            end
            HALTED: w_halt = 1'b1;
            default: w_seq = S0;
        endcase
    end

    // Strobes need reset released, the cycle enable, and (in S0) the step gate;
    // halt only depends on reset so it stays visible while frozen
    assign w_gate          = rst_n && bus.ena && w_open;
    assign bus.inc_pc      = w_gate && w_inc_pc;
    assign bus.load_pc     = w_gate && w_load_pc;
    assign bus.load_acc    = w_gate && w_load_acc;
    assign bus.load_ir     = w_gate && w_load_ir;
    assign bus.rd          = w_gate && w_rd;
    assign bus.wr          = w_gate && w_wr;
    assign bus.datactl_ena = w_gate && w_datactl;
    assign bus.halt        = rst_n && w_halt;

endmodule
